// File: rtl/rv_multicycle_datapath.sv
// rv_multicycle_datapath: multi-cycle RV32I datapath with the control FSM
// (IF/ID/EX/MEM/WB), PC, IR, register file, ALU, immediate generator and
// branch compare. Control strobes come from an external controller that
// decodes opcode/func3/func7.
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   imem_req/imem_addr/instr/instr_valid       instruction fetch handshake
//   dmem_req/we/addr/wdata/rdata/ready         data memory handshake
//   MemtoReg..jalr, branch, ALUctl             controller strobes
//   opcode, func3, func7                       IR fields for the controller
//   state                                      FSM state (IF=0..WB=4)
//   retire                                     high on the last cycle of an instruction
module rv_multicycle_datapath #(
  parameter int XLEN = 32,
  parameter int ROM_AW = 8,
  parameter int RAM_AW = 10,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ROM_AW-1:0] imem_addr,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [RAM_AW-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_ready,
  input  logic              MemtoReg,
  input  logic              ALUSrc,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              lui,
  input  logic              U_type,
  input  logic              jal,
  input  logic              jalr,
  input  logic [5:0]        branch,
  input  logic [3:0]        ALUctl,
  output logic [6:0]        opcode,
  output logic [2:0]        func3,
  output logic              func7,
  output logic [2:0]        state,
  output logic              retire
);
  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;

  state_t            state_q;
  logic [XLEN-1:0]   pc, pc_next, a, b, alu_out, mdr;
  logic [31:0]       ir;
  logic [XLEN-1:0]   rf [32];
  logic [31:0]       imm32;
  logic [XLEN-1:0]   imm, op2, alu_res, wb_data, jump_tgt;
  logic [4:0]        rs1, rs2, rd, shamt;
  logic              taken;

  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd  = ir[11:7];
  assign opcode = ir[6:0];
  assign func3  = ir[14:12];
  assign func7  = ir[30];
  assign state  = state_q;

  assign imem_req   = (state_q == S_IF);
  assign imem_addr  = pc[ROM_AW+1:2];
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = (state_q == S_MEM) & MemWrite;
  assign dmem_addr  = alu_out[RAM_AW-1:0];
  assign dmem_wdata = b;
  // Store retires straight out of MEM; everything else retires in WB.
  assign retire = (state_q == S_WB) | ((state_q == S_MEM) & MemWrite & dmem_ready);

  // Immediate by instruction format, keyed on the opcode held in IR.
  always_comb begin
    imm32 = {{20{ir[31]}}, ir[31:20]};
    case (ir[6:0])
      7'b0100011: imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      7'b1100011: imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      7'b0110111,
      7'b0010111: imm32 = {ir[31:12], 12'b0};
      7'b1101111: imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:    imm32 = {{20{ir[31]}}, ir[31:20]};
    endcase
    imm = {XLEN{imm32[31]}};
    imm[31:0] = imm32;
  end

  assign op2   = ALUSrc ? imm : b;
  assign shamt = op2[4:0];

  always_comb begin
    alu_res = '0;
    case (ALUctl)
      4'd0: alu_res = a + op2;
      4'd1: alu_res = a - op2;
      4'd2: alu_res = a << shamt;
      4'd3: alu_res[0] = $signed(a) < $signed(op2);
      4'd4: alu_res[0] = a < op2;
      4'd5: alu_res = a ^ op2;
      4'd6: alu_res = a >> shamt;
      4'd7: alu_res = $signed(a) >>> shamt;
      4'd8: alu_res = a | op2;
      4'd9: alu_res = a & op2;
      default: alu_res = '0;
    endcase
  end

  // Branch compare always looks at the two register operands, never imm.
  assign taken = (branch[0] & (a == b)) |
                 (branch[1] & (a != b)) |
                 (branch[2] & ($signed(a) <  $signed(b))) |
                 (branch[3] & ($signed(a) >= $signed(b))) |
                 (branch[4] & (a <  b)) |
                 (branch[5] & (a >= b));

  assign jump_tgt = jalr ? {alu_res[XLEN-1:1], 1'b0} :
                    (taken | jal) ? pc + imm : pc + XLEN'(4);

  // pc still holds this instruction's address here; it is updated on the same edge.
  assign wb_data = U_type ? (lui ? imm : pc + imm) :
                   (jal | jalr) ? pc + XLEN'(4) :
                   MemtoReg ? mdr : alu_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
      pc      <= RESET_PC;
      pc_next <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state_q)
        S_IF: if (instr_valid) begin
          ir      <= instr;
          state_q <= S_ID;
        end
        S_ID: begin
          // x0 is never written, so it reads its reset value of zero.
          a       <= rf[rs1];
          b       <= rf[rs2];
          state_q <= S_EX;
        end
        S_EX: begin
          alu_out <= alu_res;
          pc_next <= jump_tgt;
          state_q <= (MemRead | MemWrite) ? S_MEM : S_WB;
        end
        S_MEM: if (dmem_ready) begin
          if (MemWrite) begin
            pc      <= pc_next;
            state_q <= S_IF;
          end else begin
            mdr     <= dmem_rdata;
            state_q <= S_WB;
          end
        end
        S_WB: begin
          if (RegWrite && rd != 5'd0) rf[rd] <= wb_data;
          pc      <= pc_next;
          state_q <= S_IF;
        end
        default: state_q <= S_IF;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_multicycle_datapath.sv
// Bench for rv_multicycle_datapath. The bench plays controller and both
// memories; an architectural model (register array + pc) predicts results.
module tb_rv_multicycle_datapath;
  localparam int XLEN = 32, ROM_AW = 8, RAM_AW = 10;

  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req, instr_valid, dmem_req, dmem_we, dmem_ready, retire, func7;
  logic [ROM_AW-1:0] imem_addr;
  logic [31:0] instr;
  logic [RAM_AW-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata, dmem_rdata;
  logic MemtoReg, ALUSrc, RegWrite, MemRead, MemWrite, lui, U_type, jal, jalr;
  logic [5:0] branch;
  logic [3:0] ALUctl;
  logic [6:0] opcode;
  logic [2:0] func3, state;

  rv_multicycle_datapath #(.XLEN(XLEN), .ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .instr(instr),
    .instr_valid(instr_valid), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .lui(lui), .U_type(U_type), .jal(jal), .jalr(jalr), .branch(branch),
    .ALUctl(ALUctl), .opcode(opcode), .func3(func3), .func7(func7), .state(state), .retire(retire)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [31:0] mx [32];
  logic [31:0] mpc;
  int iw_g = 0, dw_g = 0;
  logic [31:0] ld_data = 32'h0;
  int ret_cyc, mem_cyc;
  bit mem_stable;
  logic [RAM_AW-1:0] cap_addr;
  logic cap_we;
  logic [31:0] cap_wdata;

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic alt, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {1'b0, alt, 5'b0, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm[31:12], rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  // ---------------- reference semantics ----------------
  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt, input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'd0: return alt ? x - y : x + y;
      3'd1: return x << y[4:0];
      3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: return alt ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction
  function automatic bit br_ref(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'd0: return x == y;
      3'd1: return x != y;
      3'd4: return $signed(x) < $signed(y);
      3'd5: return $signed(x) >= $signed(y);
      3'd6: return x < y;
      3'd7: return x >= y;
      default: return 1'b0;
    endcase
  endfunction
  // Controller's ALUctl for an arithmetic func3/alt pair.
  function automatic logic [3:0] ctl_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return alt ? 4'd1 : 4'd0;
      3'd1: return 4'd2;
      3'd2: return 4'd3;
      3'd3: return 4'd4;
      3'd4: return 4'd5;
      3'd5: return alt ? 4'd7 : 4'd6;
      3'd6: return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic logic [5:0] br_onehot(input logic [2:0] f3);
    case (f3)
      3'd0: return 6'b000001;
      3'd1: return 6'b000010;
      3'd4: return 6'b000100;
      3'd5: return 6'b001000;
      3'd6: return 6'b010000;
      3'd7: return 6'b100000;
      default: return 6'b0;
    endcase
  endfunction

  // Run one instruction (imm is its architectural immediate) and check it against the model.
  task automatic exec(input logic [31:0] ins, input logic [31:0] imm);
    logic [6:0] op;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic alt, wr, is_ld, is_st;
    logic [31:0] a, b, res, npc, ea;
    int lat, cyc, ifc, memc;
    bit done;
    op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; rs1 = ins[19:15]; rs2 = ins[24:20]; alt = ins[30];
    a = mx[rs1]; b = mx[rs2]; ea = a + imm; npc = mpc + 32'd4;
    wr = 1'b0; is_ld = 1'b0; is_st = 1'b0; res = 32'h0;
    case (op)
      7'h33: begin wr = 1'b1; res = alu_ref(f3, alt, a, b); end
      7'h13: begin wr = 1'b1; res = alu_ref(f3, (f3 == 3'd5) & alt, a, imm); end
      7'h03: begin wr = 1'b1; is_ld = 1'b1; res = ld_data; end
      7'h23: is_st = 1'b1;
      7'h63: if (br_ref(f3, a, b)) npc = mpc + imm;
      7'h6f: begin wr = 1'b1; res = mpc + 32'd4; npc = mpc + imm; end
      7'h67: begin wr = 1'b1; res = mpc + 32'd4; npc = ea & ~32'd1; end
      7'h37: begin wr = 1'b1; res = imm; end
      7'h17: begin wr = 1'b1; res = mpc + imm; end
      default: ;
    endcase
    lat = (is_ld ? 5 : 4) + iw_g + ((is_ld | is_st) ? dw_g : 0);
    cyc = 0; ifc = 0; memc = 0; done = 0; mem_stable = 1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      instr_valid = 1'b0; dmem_ready = 1'b0;
      if (cyc == 1) begin
        instr    = ins;
        MemtoReg = is_ld; MemRead = is_ld; MemWrite = is_st; RegWrite = wr;
        ALUSrc   = (op == 7'h13) | is_ld | is_st | (op == 7'h67);
        lui      = (op == 7'h37); U_type = (op == 7'h37) | (op == 7'h17);
        jal      = (op == 7'h6f); jalr = (op == 7'h67);
        branch   = (op == 7'h63) ? br_onehot(f3) : 6'b0;
        ALUctl   = (op == 7'h33) ? ctl_of(f3, alt) :
                   (op == 7'h13) ? ctl_of(f3, (f3 == 3'd5) & alt) : 4'd0;
      end
      if (state == 3'd0) begin
        if (ifc == 0) begin
          checks++;
          if (imem_req !== 1'b1 || imem_addr !== mpc[ROM_AW+1:2])
            begin errors++; $display("FAIL fetch_addr ins=%h got req=%b addr=%h want req=1 addr=%h", ins, imem_req, imem_addr, mpc[ROM_AW+1:2]); end
        end
        if (ifc == iw_g) instr_valid = 1'b1;
        ifc++;
      end else if (state == 3'd3) begin
        if (memc == 0) begin
          cap_addr = dmem_addr; cap_we = dmem_we; cap_wdata = dmem_wdata;
        end else if (dmem_req !== 1'b1 || dmem_addr !== cap_addr || dmem_we !== cap_we || dmem_wdata !== cap_wdata)
          mem_stable = 0;
        // Junk data until ready, so only the ready-cycle value can land.
        dmem_rdata = (memc == dw_g) ? ld_data : $urandom();
        if (memc == dw_g) dmem_ready = 1'b1;
        memc++;
      end
      #1;
      if (retire === 1'b1) begin done = 1; ret_cyc = cyc; end
    end
    mem_cyc = memc;
    checks++;
    if (!done) begin errors++; $display("FAIL retire_timeout ins=%h got none want cycle %0d", ins, lat); end
    else if (ret_cyc != lat) begin errors++; $display("FAIL latency ins=%h got %0d want %0d", ins, ret_cyc, lat); end
    if (is_ld | is_st) begin
      checks++;
      if (memc != dw_g + 1 || !mem_stable || cap_addr !== ea[RAM_AW-1:0] || cap_we !== is_st)
        begin errors++; $display("FAIL mem_access ins=%h got cyc=%0d stable=%0d addr=%h we=%b want cyc=%0d stable=1 addr=%h we=%b",
                                 ins, memc, mem_stable, cap_addr, cap_we, dw_g + 1, ea[RAM_AW-1:0], is_st); end
      if (is_st) begin
        checks++;
        if (cap_wdata !== b) begin errors++; $display("FAIL store_data ins=%h got %h want %h", ins, cap_wdata, b); end
      end
    end
    if (wr && rd != 5'd0) mx[rd] = res;
    mpc = npc;
  endtask

  task automatic addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    exec(enc_i(imm, rs1, 3'd0, rd, 7'h13), imm);
  endtask
  task automatic sw0(input logic [4:0] rs2);
    exec(enc_s(32'h0, rs2, 5'd0), 32'h0);
  endtask
  task automatic goto(input logic [31:0] tgt);
    exec(enc_i(tgt, 5'd0, 3'd0, 5'd0, 7'h67), tgt);
  endtask
  task automatic model_reset();
    for (int i = 0; i < 32; i++) mx[i] = 32'h0;
    mpc = 32'h0;
  endtask
  task automatic peek_pc(input logic [31:0] want, input string nm);
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || imem_addr !== want[ROM_AW+1:2])
      begin errors++; $display("FAIL %s got state=%0d addr=%h want state=0 addr=%h", nm, state, imem_addr, want[ROM_AW+1:2]); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    instr = 32'h0; instr_valid = 0; dmem_ready = 0; dmem_rdata = 0;
    {MemtoReg, ALUSrc, RegWrite, MemRead, MemWrite, lui, U_type, jal, jalr} = '0;
    branch = '0; ALUctl = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 3'd0 || imem_req !== 1'b1 || imem_addr !== '0 || retire !== 1'b0 || dmem_req !== 1'b0)
      begin errors++; $display("FAIL reset_state got st=%0d req=%b addr=%h ret=%b dreq=%b want 0 1 0 0 0", state, imem_req, imem_addr, retire, dmem_req); end
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    iw_g = 0; dw_g = 0;
    exec(32'h00500093, 32'd5);
    checks++;
    if (ret_cyc != 4) begin errors++; $display("FAIL addi_latency got %0d want 4", ret_cyc); end
    peek_pc(32'h4, "addi_pc");
    sw0(5'd1);
    checks++;
    if (cap_wdata !== 32'd5) begin errors++; $display("FAIL addi_x1 got %h want 5", cap_wdata); end
  endtask

  task automatic test_load_wait();
    dw_g = 3; ld_data = 32'hDEADBEEF;
    exec(enc_i(32'h0, 5'd0, 3'd2, 5'd2, 7'h03), 32'h0);
    checks++;
    if (ret_cyc != 8 || mem_cyc != 4 || !mem_stable)
      begin errors++; $display("FAIL load_wait got ret=%0d mem=%0d stable=%0d want 8 4 1", ret_cyc, mem_cyc, mem_stable); end
    dw_g = 0;
    sw0(5'd2);
    checks++;
    if (cap_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_x2 got %h want deadbeef", cap_wdata); end
  endtask

  task automatic test_branch();
    addi(5'd1, 5'd0, 32'd5);
    addi(5'd3, 5'd0, 32'd5);
    goto(32'h10);
    exec(enc_b(32'd8, 5'd3, 5'd1, 3'd0), 32'd8);
    peek_pc(32'h18, "beq_taken");
    addi(5'd3, 5'd0, 32'd6);
    goto(32'h10);
    exec(enc_b(32'd8, 5'd3, 5'd1, 3'd0), 32'd8);
    peek_pc(32'h14, "beq_not_taken");
    addi(5'd1, 5'd0, 32'hFFFFFFFF);
    addi(5'd3, 5'd0, 32'd1);
    goto(32'h20);
    exec(enc_b(32'd12, 5'd3, 5'd1, 3'd4), 32'd12);
    peek_pc(32'h2C, "blt_taken");
    goto(32'h20);
    exec(enc_b(32'd12, 5'd3, 5'd1, 3'd6), 32'd12);
    peek_pc(32'h24, "bltu_not_taken");
  endtask

  task automatic test_jump();
    goto(32'h40);
    exec(enc_j(32'h20, 5'd1), 32'h20);
    peek_pc(32'h60, "jal_target");
    sw0(5'd1);
    checks++;
    if (cap_wdata !== 32'h44) begin errors++; $display("FAIL jal_link got %h want 44", cap_wdata); end
    addi(5'd5, 5'd0, 32'h100);
    exec(enc_i(32'd3, 5'd5, 3'd0, 5'd0, 7'h67), 32'd3);
    peek_pc(32'h102, "jalr_target");
    sw0(5'd0);
    checks++;
    if (cap_wdata !== 32'h0) begin errors++; $display("FAIL jalr_x0 got %h want 0", cap_wdata); end
  endtask

  task automatic test_upper();
    exec(enc_u(32'h12345000, 5'd4, 7'h37), 32'h12345000);
    sw0(5'd4);
    checks++;
    if (cap_wdata !== 32'h12345000) begin errors++; $display("FAIL lui got %h want 12345000", cap_wdata); end
    goto(32'h8);
    exec(enc_u(32'h1000, 5'd4, 7'h17), 32'h1000);
    sw0(5'd4);
    checks++;
    if (cap_wdata !== 32'h1008) begin errors++; $display("FAIL auipc got %h want 1008", cap_wdata); end
    addi(5'd0, 5'd0, 32'd7);
    sw0(5'd0);
    checks++;
    if (cap_wdata !== 32'h0) begin errors++; $display("FAIL x0_write got %h want 0", cap_wdata); end
  endtask

  task automatic test_reset_mid_store();
    bit hit, saw_ret;
    addi(5'd6, 5'd0, 32'd77);
    hit = 0; saw_ret = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      instr_valid = 1'b0; dmem_ready = 1'b0;
      if (c == 0) begin
        instr = enc_s(32'd4, 5'd6, 5'd0);
        {MemtoReg, RegWrite, MemRead, lui, U_type, jal, jalr} = '0;
        MemWrite = 1'b1; ALUSrc = 1'b1; branch = '0; ALUctl = 4'd0;
      end
      if (state == 3'd0) instr_valid = 1'b1;
      if (state == 3'd3 && dmem_req === 1'b1) begin
        hit = 1;
        rst_n = 1'b0;
      end
      #1;
      if (retire === 1'b1) saw_ret = 1;
    end
    checks++;
    if (!hit || saw_ret || state !== 3'd0 || imem_addr !== '0 || retire !== 1'b0 || dmem_req !== 1'b0)
      begin errors++; $display("FAIL reset_in_mem got hit=%0d ret_seen=%0d st=%0d addr=%h ret=%b dreq=%b want 1 0 0 0 0 0",
                               hit, saw_ret, state, imem_addr, retire, dmem_req); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    addi(5'd0, 5'd0, 32'd0);
    sw0(5'd6);
    checks++;
    if (cap_wdata !== 32'h0) begin errors++; $display("FAIL reset_clears_regs got %h want 0", cap_wdata); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      int k, v;
      logic [4:0] rd, rs1, rs2;
      logic [2:0] f3;
      logic alt;
      logic [31:0] imm;
      iw_g = $urandom_range(0, 2); dw_g = $urandom_range(0, 3);
      ld_data = $urandom();
      rd = 5'($urandom()); rs1 = 5'($urandom()); rs2 = 5'($urandom());
      f3 = 3'($urandom()); alt = 1'($urandom());
      v = int'($urandom_range(0, 4095)) - 2048; imm = 32'(v);
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: exec(enc_r((f3 == 3'd0 || f3 == 3'd5) ? alt : 1'b0, rs2, rs1, f3, rd), 32'h0);
        3, 4: begin
          if (f3 == 3'd1) imm = {27'h0, rs2};
          else if (f3 == 3'd5) imm = alt ? {20'h0, 12'h400 | {7'h0, rs2}} : {27'h0, rs2};
          exec(enc_i(imm, rs1, f3, rd, 7'h13), imm);
        end
        5: exec(enc_i(imm, rs1, 3'd2, rd, 7'h03), imm);
        6: exec(enc_s(imm, rs2, rs1), imm);
        7: begin
          if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd0;
          v = (int'($urandom_range(0, 64)) - 32) * 2; imm = 32'(v);
          exec(enc_b(imm, rs2, rs1, f3), imm);
        end
        8: begin
          imm = {20'($urandom()), 12'h0};
          exec(enc_u(imm, rd, alt ? 7'h37 : 7'h17), imm);
        end
        default: begin
          if (alt) begin
            v = (int'($urandom_range(0, 1024)) - 512) * 2; imm = 32'(v);
            exec(enc_j(imm, rd), imm);
          end else exec(enc_i(imm, rs1, 3'd0, rd, 7'h67), imm);
        end
      endcase
    end
    iw_g = 0; dw_g = 0;
    for (int r = 1; r < 32; r++) begin
      sw0(5'(r));
      checks++;
      if (cap_wdata !== mx[r]) begin errors++; $display("FAIL random_reg x%0d got %h want %h", r, cap_wdata, mx[r]); end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_wait();
    test_branch();
    test_jump();
    test_upper();
    test_reset_mid_store();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_multicycle_datapath.md
Name: rv_multicycle_datapath

Overview:
Parametrised multi-cycle successor to the single-cycle RV32I datapath. It runs each instruction through an internal FSM (IF/ID/EX/MEM/WB) with valid/ready handshakes on the instruction and data memories, so memories with wait states are supported. It holds the PC, instruction register, register file, ALU, immediate generator and branch compare. An external controller supplies the control strobes decoded from the opcode/func3/func7 outputs.

Parameters:
XLEN, 32, datapath and register width (≥32).
ROM_AW, 8, instruction-word address width; imem_addr = pc[ROM_AW+1:2].
RAM_AW, 10, data byte-address width driven on dmem_addr.
RESET_PC, 0, PC value loaded at reset.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request, high throughout IF
imem_addr  out  ROM_AW  word address of the fetch
instr  in  32  fetched instruction
instr_valid  in  1  instr valid this cycle; completes the fetch
dmem_req  out  1  data request, high throughout MEM
dmem_we  out  1  store when 1, load when 0; valid with dmem_req
dmem_addr  out  RAM_AW  ALUOut[RAM_AW-1:0]
dmem_wdata  out  XLEN  rs2 value latched in ID
dmem_rdata  in  XLEN  load data, sampled when dmem_ready
dmem_ready  in  1  completes the data access
MemtoReg, ALUSrc, RegWrite, MemRead, MemWrite, lui, U_type, jal, jalr  in  1 each  controller strobes, stable from ID through WB
branch  in  6  {bgeu,bltu,bge,blt,bne,beq}, at most one bit set
ALUctl  in  4  ALU operation
opcode  out  7  IR[6:0]
func3  out  3  IR[14:12]
func7  out  1  IR[30]
state  out  3  IF=0, ID=1, EX=2, MEM=3, WB=4
retire  out  1  one-cycle pulse on the last cycle of each instruction

Behaviour:
- Reset (async, rst_n low): pc=RESET_PC, state=IF, IR=0, A/B/ALUOut/MDR=0, all 32 registers=0, retire=0. imem_req reads 1 because it decodes IF; memories ignore requests while in reset. Reset in any state aborts the instruction with no register write.
- IF: imem_req=1. When instr_valid=1, IR<=instr and go to ID; otherwise stay in IF. Unbounded wait.
- ID: A<=x[rs1], B<=x[rs2]. imm is decoded from IR by format (I/S/B/U/J), sign-extended to XLEN. Go to EX.
- EX: ALUOut<=ALU(A, ALUSrc?imm:B, ALUctl).
  - ALUctl codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; others give 0. Shift amount is operand[4:0]. Arithmetic wraps modulo 2^XLEN.
  - Branch taken = beq&(A==B) | bne&(A!=B) | blt&(A<B signed) | bge&(A>=B signed) | bltu&(A<B unsigned) | bgeu&(A>=B unsigned).
  - pc_next = jalr ? {ALU[XLEN-1:1],0} : (taken|jal) ? pc+imm : pc+4; latched here.
  - Next state is MEM if MemRead|MemWrite, else WB.
- MEM: dmem_req=1; dmem_addr, dmem_we (=MemWrite) and dmem_wdata are held stable until dmem_ready.
  - Load: on dmem_ready, MDR<=dmem_rdata, go to WB.
  - Store: on dmem_ready, pc<=pc_next, retire=1, go to IF.
  - Word accesses only.
- WB:
  - wdata = U_type ? (lui ? imm : pc+imm) : (jal|jalr) ? pc+4 : MemtoReg ? MDR : ALUOut.
  - Write happens if RegWrite and rd≠0; x0 always reads 0.
  - pc<=pc_next, retire=1, go to IF.
  - The pc used for auipc/link is the pre-update pc of the instruction.
- Latency with zero-wait memories: ALU/branch/jump/U-type 4 cycles, store 4, load 5. Each memory wait cycle adds one cycle.
- A register written in WB is visible to the next instruction's ID; there are no hazards.
- Branch/jal targets are not alignment-checked; imem_addr drops pc[1:0].
- Only the ALU, ALUOut and registered outputs change; the controller must not change strobes mid-instruction.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093), zero-wait → retire at cycle 4, x1=5, pc=4, imem_addr=1.
- lw x2,0(x0) with dmem_ready delayed 3 cycles, dmem_rdata=0xDEADBEEF → dmem_req held 4 cycles with addr/we stable; x2=0xDEADBEEF; retire at cycle 8.
- x1=5, x3=5: beq x1,x3,+8 at pc=0x10 → pc=0x18. Same with x3=6 → pc=0x14. blt/bltu with x1=-1, x3=1 → signed branch taken, unsigned not taken.
- jal x1,+0x20 at pc=0x40 → x1=0x44, pc=0x60. jalr x0,3(x5) with x5=0x100 → pc=0x102, no register write.
- lui x4,0x12345 → x4=0x12345000. auipc x4,1 at pc=0x8 → x4=0x1008. addi x0,x0,7 → x0 reads 0.
- Deassert rst_n during MEM of a store while dmem_req=1 → state=IF, pc=RESET_PC, registers=0, no retire. The subsequent fetch proceeds normally.
